// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch sequencer: owns the PC, tracks the single outstanding request and
// tells the top when a response (or the skid buffer) may enter IF/ID.
module fetch_fsm
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            rvalid,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic            load_resp,
  output logic            load_hold,
  output logic            capture_hold
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(INSTR_BYTES);
  assign pc     = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    load_resp    = 1'b0;
    load_hold    = 1'b0;
    capture_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_sel) begin
          pc_d = redirect_pc;
        end else begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (rvalid) begin
          if (pc_sel) begin
            pc_d    = redirect_pc;
            state_d = IDLE;
          end else if (stall) begin
            capture_hold = 1'b1;
            state_d      = HOLD;
          end else begin
            // Consume and re-issue in the same cycle for back-to-back fetch.
            load_resp = 1'b1;
            imem_req  = 1'b1;
            imem_addr = pc_inc;
            pc_d      = pc_inc;
          end
        end else if (pc_sel) begin
          pc_d    = redirect_pc;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (pc_sel) begin
          pc_d    = redirect_pc;
          state_d = IDLE;
        end else if (!stall) begin
          load_hold = 1'b1;
          imem_req  = 1'b1;
          imem_addr = pc_inc;
          pc_d      = pc_inc;
          state_d   = WAIT;
        end
      end
      DROP: begin
        // Wrong-path response still in flight; wait for it before refetching.
        if (pc_sel) pc_d = redirect_pc;
        if (rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      imem_req     = 1'b0;
      load_resp    = 1'b0;
      load_hold    = 1'b0;
      capture_hold = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing via fetch_fsm, a one-word skid
// buffer for responses that land during a stall, and the IF/ID register.
module fetch_unit #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            flush
);
  import fetch_pkg::*;

  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] fsm_pc;
  logic            load_resp, load_hold, capture_hold;
  logic            unused_brpc_bits;

  logic [31:0]     hold_q, hold_d;
  logic [PC_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;

  // Targets are word aligned; a jalr-style odd target is rounded down.
  assign redirect_pc      = {BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc_bits = ^{BrPC[31:PC_W], BrPC[1:0]};

  assign flush = PcSel & ~reset;

  fetch_fsm #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_sel       (PcSel),
    .redirect_pc  (redirect_pc),
    .rvalid       (imem_rvalid),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (fsm_pc),
    .load_resp    (load_resp),
    .load_hold    (load_hold),
    .capture_hold (capture_hold)
  );

  always_comb begin
    hold_d        = capture_hold ? imem_rdata : hold_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (PcSel) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (load_resp) begin
        if_id_pc_d    = fsm_pc;
        if_id_instr_d = imem_rdata;
        if_id_valid_d = 1'b1;
      end else if (load_hold) begin
        if_id_pc_d    = fsm_pc;
        if_id_instr_d = hold_q;
        if_id_valid_d = 1'b1;
      end else begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (reset) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam int          PC_W = 9;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset, stall, PcSel;
  logic [31:0]     BrPC;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            flush;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .flush       (flush)
  );

  int n_chk = 0;
  int n_err = 0;

  // Memory: one pending request, delivered after mem_cnt cycles.
  bit              mem_pend = 1'b0;
  int              mem_cnt  = 0;
  logic [31:0]     mem_data = '0;
  int              lat_fix  = 1;
  bit              ovr_en   = 1'b0;
  logic [PC_W-1:0] ovr_addr = '0;
  logic [31:0]     ovr_data = '0;

  // Model: is a request in flight, is it wrong-path, is a word parked.
  bit              m_known    = 1'b0;
  bit              m_inflight = 1'b0;
  bit              m_stale    = 1'b0;
  bit              m_buf      = 1'b0;
  logic [31:0]     m_buf_word = '0;
  logic [PC_W-1:0] m_cur_pc   = '0;
  logic [PC_W-1:0] m_next_pc  = '0;
  logic [PC_W-1:0] m_if_pc    = '0;
  logic [31:0]     m_if_instr = '0;
  bit              m_if_valid = 1'b0;

  // Values seen on the DUT at the most recent sample point.
  logic            s_req, s_flush, s_ifvalid;
  logic [PC_W-1:0] s_addr, s_ifpc;
  logic [31:0]     s_ifinstr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit ps, input logic [31:0] br);
    bit              arrive, consume, free, exp_req, exp_flush;
    logic [PC_W-1:0] exp_addr, tgt;
    logic [31:0]     word;
    reset = rst; stall = st; PcSel = ps; BrPC = br;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend) begin
      if (mem_cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
        mem_pend    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    @(negedge clk);
    arrive    = m_inflight && imem_rvalid;
    consume   = ((arrive && !m_stale) || m_buf) && !ps && !st;
    free      = !m_inflight && !m_buf;
    exp_req   = !rst && !ps && (free || consume);
    exp_addr  = consume ? m_cur_pc + PC_W'(4) : m_next_pc;
    exp_flush = ps && !rst;
    s_req = imem_req; s_addr = imem_addr; s_flush = flush;
    s_ifpc = if_id_pc; s_ifinstr = if_id_instr; s_ifvalid = if_id_valid;
    chk("imem_req", 32'(s_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(s_addr), 32'(exp_addr));
    chk("flush", 32'(s_flush), 32'(exp_flush));
    if (m_known) begin
      chk("if_id_valid", 32'(s_ifvalid), 32'(m_if_valid));
      chk("if_id_instr", s_ifinstr, m_if_instr);
      chk("if_id_pc", 32'(s_ifpc), 32'(m_if_pc));
    end
    if (imem_req) begin
      mem_pend = 1'b1;
      mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      mem_data = (ovr_en && imem_addr == ovr_addr) ? ovr_data : (32'hC0DE0000 | 32'(imem_addr));
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1; m_inflight = 1'b0; m_stale = 1'b0; m_buf = 1'b0;
      m_next_pc = '0; m_if_pc = '0; m_if_instr = NOP; m_if_valid = 1'b0;
    end else begin
      word = m_buf ? m_buf_word : imem_rdata;
      tgt  = {br[PC_W-1:2], 2'b00};
      if (ps) begin
        m_if_valid = 1'b0; m_if_instr = NOP;
      end else if (!st) begin
        if (consume) begin
          m_if_pc = m_cur_pc; m_if_instr = word; m_if_valid = 1'b1;
        end else begin
          m_if_valid = 1'b0; m_if_instr = NOP;
        end
      end
      if (arrive && !m_stale && !ps && st) begin
        m_buf = 1'b1; m_buf_word = imem_rdata;
      end
      if (consume) m_buf = 1'b0;
      if (arrive) begin
        m_inflight = 1'b0; m_stale = 1'b0;
      end
      if (ps) begin
        m_buf = 1'b0; m_next_pc = tgt;
        if (m_inflight) m_stale = 1'b1;
      end
      if (exp_req) begin
        m_inflight = 1'b1; m_stale = 1'b0; m_cur_pc = exp_addr; m_next_pc = exp_addr;
      end
    end
    #1;
  endtask

  task automatic fresh(input int lat);
    lat_fix  = lat;
    mem_pend = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; PcSel = 1'b0; BrPC = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk); #1;

    // Straight-line fetch with a 1-cycle memory.
    fresh(1);
    chk("rst_req", 32'(s_req), 32'h0);
    cycle(0, 0, 0, 0);
    chk("seq_a0", 32'(s_addr), 32'h000);
    chk("rst_valid", 32'(s_ifvalid), 32'h0);
    chk("rst_instr", s_ifinstr, NOP);
    chk("rst_pc", 32'(s_ifpc), 32'h0);
    cycle(0, 0, 0, 0);
    chk("seq_a4", 32'(s_addr), 32'h004);
    cycle(0, 0, 0, 0);
    chk("seq_a8", 32'(s_addr), 32'h008);
    chk("seq_pc0", 32'(s_ifpc), 32'h000);
    chk("seq_v0", 32'(s_ifvalid), 32'h1);
    cycle(0, 0, 0, 0);
    chk("seq_a12", 32'(s_addr), 32'h00C);
    chk("seq_pc4", 32'(s_ifpc), 32'h004);

    // Stall while the pc 8 response lands.
    ovr_en = 1'b1; ovr_addr = 9'h008; ovr_data = 32'hAAAA0001;
    fresh(1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("hold_noreq0", 32'(s_req), 32'h0);
    cycle(0, 1, 0, 0);
    chk("hold_noreq1", 32'(s_req), 32'h0);
    cycle(0, 1, 0, 0);
    chk("hold_noreq2", 32'(s_req), 32'h0);
    chk("hold_ifpc", 32'(s_ifpc), 32'h004);
    cycle(0, 0, 0, 0);
    chk("hold_req", 32'(s_req), 32'h1);
    chk("hold_next", 32'(s_addr), 32'h00C);
    cycle(0, 0, 0, 0);
    chk("hold_ifpc8", 32'(s_ifpc), 32'h008);
    chk("hold_instr", s_ifinstr, 32'hAAAA0001);
    chk("hold_valid", 32'(s_ifvalid), 32'h1);
    ovr_en = 1'b0;

    // Redirect while a 3-cycle fetch of 0x10 is in flight.
    fresh(3);
    cycle(0, 0, 1, 32'h10);
    cycle(0, 0, 0, 0);
    chk("drop_a10", 32'(s_addr), 32'h010);
    cycle(0, 0, 1, 32'h40);
    chk("drop_flush", 32'(s_flush), 32'h1);
    cycle(0, 0, 0, 0);
    chk("drop_v", 32'(s_ifvalid), 32'h0);
    cycle(0, 0, 0, 0);
    chk("drop_stale_req", 32'(s_req), 32'h0);
    cycle(0, 0, 0, 0);
    chk("drop_a40", 32'(s_addr), 32'h040);
    chk("drop_v2", 32'(s_ifvalid), 32'h0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Redirect and stall together with a response at the same edge.
    fresh(1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'h80);
    cycle(0, 0, 0, 0);
    chk("ps_st_valid", 32'(s_ifvalid), 32'h0);
    chk("ps_st_instr", s_ifinstr, 32'h00000013);
    chk("ps_st_addr", 32'(s_addr), 32'h080);

    // Wrap-around at the top of the 9-bit space.
    fresh(1);
    cycle(0, 0, 1, 32'h1FC);
    cycle(0, 0, 0, 0);
    chk("wrap_a1fc", 32'(s_addr), 32'h1FC);
    cycle(0, 0, 0, 0);
    chk("wrap_a000", 32'(s_addr), 32'h000);

    // Misaligned jalr target.
    fresh(1);
    cycle(0, 0, 1, 32'h103);
    cycle(0, 0, 0, 0);
    chk("jalr_addr", 32'(s_addr), 32'h100);

    // Reset while waiting; the old response comes back after reset.
    fresh(3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("rst_mid_rvalid_seen", 32'(imem_rvalid), 32'h1);
    chk("rst_mid_addr", 32'(s_addr), 32'h000);
    cycle(0, 0, 0, 0);
    chk("rst_mid_valid", 32'(s_ifvalid), 32'h0);

    // Randomized traffic.
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
